// File: rtl/multiport_cache.sv
// Fully associative cache with NRD single-cycle read channels and one write port.
// Writes replace lines using a second-chance (clock) policy.
module multiport_cache #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned K          = 4,
  parameter int unsigned NRD        = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NRD-1:0]               rd_en,
  input  logic [NRD*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NRD-1:0]               rd_hit,
  output logic [NRD*LINE_WIDTH-1:0]    rd_val,
  input  logic                         wr_valid,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LINE_WIDTH-1:0]        wr_val,
  output logic                         wr_ready,
  output logic                         wr_done,
  output logic                         evict_valid,
  output logic [ADDR_WIDTH-1:0]        evict_addr,
  output logic [LINE_WIDTH-1:0]        evict_val,
  output logic [$clog2(K+1)-1:0]       occupancy
);

  localparam int unsigned IW = $clog2(K);
  localparam int unsigned OW = $clog2(K + 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           hand_q, hand_d, hand_nxt;
  logic [K-1:0]            valid_q, valid_d;
  logic [K-1:0]            ref_q, ref_d;
  logic [ADDR_WIDTH-1:0]   addr_q [K];
  logic [LINE_WIDTH-1:0]   val_q  [K];
  logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
  logic [LINE_WIDTH-1:0]   cap_val_q, cap_val_d;

  logic [NRD-1:0]          rd_hit_q, rd_hit_d;
  logic [NRD*LINE_WIDTH-1:0] rd_val_q, rd_val_d;
  logic                    wr_done_q, wr_done_d;
  logic                    evict_valid_q, evict_valid_d;
  logic [ADDR_WIDTH-1:0]   evict_addr_q, evict_addr_d;
  logic [LINE_WIDTH-1:0]   evict_val_q, evict_val_d;
  logic [OW-1:0]           occ_q, occ_d;

  logic                    wr_hit, free_found, line_we;
  logic [IW-1:0]           wr_hit_idx, free_idx, line_idx;
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic [LINE_WIDTH-1:0]   line_val;

  assign wr_ready    = (state_q == IDLE) && !reset;
  assign rd_hit      = rd_hit_q;
  assign rd_val      = rd_val_q;
  assign wr_done     = wr_done_q;
  assign evict_valid = evict_valid_q;
  assign evict_addr  = evict_addr_q;
  assign evict_val   = evict_val_q;
  assign occupancy   = occ_q;

  assign hand_nxt = (hand_q == IW'(K - 1)) ? '0 : hand_q + IW'(1);

  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (valid_q[i] && addr_q[i] == wr_addr) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IW'(i);
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = K; i > 0; i--) begin
      if (!valid_q[i-1]) begin
        free_found = 1'b1;
        free_idx   = IW'(i - 1);
      end
    end
  end

  always_comb begin
    rd_hit_d      = rd_hit_q;
    rd_val_d      = rd_val_q;
    valid_d       = valid_q;
    ref_d         = ref_q;
    state_d       = state_q;
    hand_d        = hand_q;
    cap_addr_d    = cap_addr_q;
    cap_val_d     = cap_val_q;
    wr_done_d     = 1'b0;
    evict_valid_d = 1'b0;
    evict_addr_d  = evict_addr_q;
    evict_val_d   = evict_val_q;
    occ_d         = occ_q;
    line_we       = 1'b0;
    line_idx      = '0;
    line_addr     = wr_addr;
    line_val      = wr_val;

    for (int unsigned c = 0; c < NRD; c++) begin
      if (rd_en[c]) begin
        rd_hit_d[c]                         = 1'b0;
        rd_val_d[c*LINE_WIDTH +: LINE_WIDTH] = '0;
        for (int unsigned i = 0; i < K; i++) begin
          if (valid_q[i] && addr_q[i] == rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]) begin
            rd_hit_d[c]                         = 1'b1;
            rd_val_d[c*LINE_WIDTH +: LINE_WIDTH] = val_q[i];
            ref_d[i]                            = 1'b1;
          end
        end
      end
    end

    // Scan updates come after read-hit ref sets so a same-cycle clear wins.
    unique case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready) begin
          if (wr_hit) begin
            line_we         = 1'b1;
            line_idx        = wr_hit_idx;
            ref_d[wr_hit_idx] = 1'b1;
            wr_done_d       = 1'b1;
          end else if (free_found) begin
            line_we           = 1'b1;
            line_idx          = free_idx;
            valid_d[free_idx] = 1'b1;
            ref_d[free_idx]   = 1'b1;
            wr_done_d         = 1'b1;
            if (occ_q < OW'(K)) occ_d = occ_q + OW'(1);
          end else begin
            state_d    = SCAN;
            cap_addr_d = wr_addr;
            cap_val_d  = wr_val;
          end
        end
      end
      SCAN: begin
        hand_d = hand_nxt;
        if (ref_q[hand_q]) begin
          ref_d[hand_q] = 1'b0;
        end else begin
          evict_valid_d = 1'b1;
          evict_addr_d  = addr_q[hand_q];
          evict_val_d   = val_q[hand_q];
          line_we       = 1'b1;
          line_idx      = hand_q;
          line_addr     = cap_addr_q;
          line_val      = cap_val_q;
          ref_d[hand_q] = 1'b1;
          wr_done_d     = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      hand_q        <= '0;
      valid_q       <= '0;
      ref_q         <= '0;
      rd_hit_q      <= '0;
      rd_val_q      <= '0;
      wr_done_q     <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_val_q   <= '0;
      occ_q         <= '0;
      cap_addr_q    <= '0;
      cap_val_q     <= '0;
    end else begin
      state_q       <= state_d;
      hand_q        <= hand_d;
      valid_q       <= valid_d;
      ref_q         <= ref_d;
      rd_hit_q      <= rd_hit_d;
      rd_val_q      <= rd_val_d;
      wr_done_q     <= wr_done_d;
      evict_valid_q <= evict_valid_d;
      evict_addr_q  <= evict_addr_d;
      evict_val_q   <= evict_val_d;
      occ_q         <= occ_d;
      cap_addr_q    <= cap_addr_d;
      cap_val_q     <= cap_val_d;
      if (line_we) begin
        addr_q[line_idx] <= line_addr;
        val_q[line_idx]  <= line_val;
      end
    end
  end

endmodule

// File: tb/tb_multiport_cache.sv
// Bench for multiport_cache (K=4, NRD=2): directed scenarios plus a read-vector
// table, with read expectations queued when driven and checked one cycle later.
module tb_multiport_cache;

  localparam int unsigned AW = 8;
  localparam int unsigned LW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]    rd_hit;
  logic [2*LW-1:0] rd_val;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_val;
  logic          wr_ready, wr_done, evict_valid;
  logic [AW-1:0] evict_addr;
  logic [LW-1:0] evict_val;
  logic [2:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  multiport_cache #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .K(4), .NRD(2)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_val(rd_val),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_val(wr_val),
    .wr_ready(wr_ready), .wr_done(wr_done),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_val(evict_val),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    hit;
    logic [LW-1:0] v0;
    logic [LW-1:0] v1;
  } rd_exp_t;

  typedef struct {
    string         name;
    logic [1:0]    en;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    hit;
    logic [LW-1:0] v0;
    logic [LW-1:0] v1;
  } vec_t;

  rd_exp_t sb[$];
  vec_t    vt[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [1:0] en, input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1, input logic [1:0] hit,
                    input logic [LW-1:0] v0, input logic [LW-1:0] v1);
    rd_exp_t e;
    e.hit = hit; e.v0 = v0; e.v1 = v1;
    rd_en   = en;
    rd_addr = {a1, a0};
    sb.push_back(e);
    tick();
    rd_en = 2'b00;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_hit"}, 64'(rd_hit), 64'(e.hit));
      chk({name, "_v0"}, 64'(rd_val[LW-1:0]), 64'(e.v0));
      chk({name, "_v1"}, 64'(rd_val[2*LW-1:LW]), 64'(e.v1));
    end
  endtask

  task automatic wr(input string name, input logic [AW-1:0] a, input logic [LW-1:0] v,
                    input logic [2:0] exp_occ);
    wr_valid = 1'b1; wr_addr = a; wr_val = v;
    tick();
    wr_valid = 1'b0;
    chk({name, "_done"}, 64'(wr_done), 64'd1);
    chk({name, "_occ"}, 64'(occupancy), 64'(exp_occ));
  endtask

  // Issues a write that must miss on a full cache; returns SCAN length in cycles.
  task automatic wr_scan(input string name, input logic [AW-1:0] a, input logic [LW-1:0] v,
                         output int cycles);
    wr_valid = 1'b1; wr_addr = a; wr_val = v;
    tick();
    wr_valid = 1'b0; wr_addr = 8'hEE; wr_val = 32'hDEAD_BEEF;
    chk({name, "_accept_nodone"}, 64'(wr_done), 64'd0);
    cycles = 0;
    while (!evict_valid && cycles < 10) begin
      chk({name, "_ready_low"}, 64'(wr_ready), 64'd0);
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;

    vt[0] = '{"t0", 2'b11, 8'h06, 8'h04, 2'b11, 32'h6666_0006, 32'hD000_0004};
    vt[1] = '{"t1", 2'b01, 8'h02, 8'h00, 2'b10, 32'h0,         32'hD000_0004};
    vt[2] = '{"t2", 2'b10, 8'h00, 8'h01, 2'b00, 32'h0,         32'h0};
    vt[3] = '{"t3", 2'b00, 8'h03, 8'h03, 2'b00, 32'h0,         32'h0};
    vt[4] = '{"t4", 2'b11, 8'h03, 8'h05, 2'b11, 32'hD000_0003, 32'h0000_1234};
    vt[5] = '{"t5", 2'b10, 8'h00, 8'h7F, 2'b01, 32'hD000_0003, 32'h0};

    reset = 1'b1; rd_en = '0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_val = '0;
    tick();
    tick();
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_hit", 64'(rd_hit), 64'd0);
    chk("rst_rd_val", rd_val, 64'd0);
    chk("rst_outs", {wr_done, evict_valid, evict_addr, evict_val, occupancy}, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);

    // Empty-cache miss, then single fill and hit, then hold with rd_en low.
    rd("empty_miss", 2'b01, 8'h7F, 8'h00, 2'b00, 32'h0, 32'h0);
    wr("w10", 8'h10, 32'hAAAA_0001, 3'd1);
    tick();
    chk("w10_done_pulse", 64'(wr_done), 64'd0);
    rd("hit10", 2'b01, 8'h10, 8'h00, 2'b01, 32'hAAAA_0001, 32'h0);
    rd("hold", 2'b00, 8'h7F, 8'h7F, 2'b01, 32'hAAAA_0001, 32'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_occ", 64'(occupancy), 64'd0);

    // Fill four lines, then force a full second-chance sweep.
    for (int i = 1; i <= 4; i++) wr("fill", 8'(i), 32'hD000_0000 | 32'(i), 3'(i));
    wr_scan("w05", 8'h05, 32'h5555_0005, cyc);
    chk("w05_scan_len", 64'(cyc), 64'd5);
    chk("w05_evict_addr", 64'(evict_addr), 64'h01);
    chk("w05_evict_val", 64'(evict_val), 64'hD000_0001);
    chk("w05_done", 64'(wr_done), 64'd1);
    chk("w05_occ", 64'(occupancy), 64'd4);
    chk("w05_ready_back", 64'(wr_ready), 64'd1);
    tick();
    chk("w05_pulses_end", {62'd0, evict_valid, wr_done}, 64'd0);
    chk("w05_evict_hold", 64'(evict_addr), 64'h01);

    // Hand at line 1; a read hit on line 2 must not redirect the victim.
    rd("hit03", 2'b10, 8'h00, 8'h03, 2'b10, 32'h0, 32'hD000_0003);
    wr_scan("w06", 8'h06, 32'h6666_0006, cyc);
    chk("w06_scan_len", 64'(cyc), 64'd1);
    chk("w06_evict_addr", 64'(evict_addr), 64'h02);
    chk("w06_evict_val", 64'(evict_val), 64'hD000_0002);

    // Both channels read a line in the same cycle it is overwritten.
    wr_valid = 1'b1; wr_addr = 8'h05; wr_val = 32'h0000_1234;
    rd("rbw", 2'b11, 8'h05, 8'h05, 2'b11, 32'h5555_0005, 32'h5555_0005);
    wr_valid = 1'b0;
    chk("rbw_done", 64'(wr_done), 64'd1);
    chk("rbw_occ", 64'(occupancy), 64'd4);
    chk("rbw_no_evict", 64'(evict_valid), 64'd0);
    rd("rbw_new", 2'b01, 8'h05, 8'h00, 2'b11, 32'h0000_1234, 32'h5555_0005);

    for (int i = 0; i < 6; i++)
      rd(vt[i].name, vt[i].en, vt[i].a0, vt[i].a1, vt[i].hit, vt[i].v0, vt[i].v1);

    // All refs set: reset lands in the second SCAN cycle, with traffic present.
    wr_valid = 1'b1; wr_addr = 8'h07; wr_val = 32'h7777_0007;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("scan1_no_evict", {62'd0, evict_valid, wr_done}, 64'd0);
    reset = 1'b1; rd_en = 2'b11; rd_addr = {8'h05, 8'h06};
    wr_valid = 1'b1; wr_addr = 8'h06; wr_val = 32'hFFFF_FFFF;
    tick();
    chk("rst_scan_pulses", {62'd0, evict_valid, wr_done}, 64'd0);
    chk("rst_scan_occ", 64'(occupancy), 64'd0);
    chk("rst_scan_rd_hit", 64'(rd_hit), 64'd0);
    chk("rst_scan_rd_val", rd_val, 64'd0);
    chk("rst_scan_ready", 64'(wr_ready), 64'd0);
    reset = 1'b0; rd_en = 2'b00; wr_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= wr_done | evict_valid;
    end
    chk("rst_scan_abandon", 64'(seen), 64'd0);
    chk("rst_scan_ready_back", 64'(wr_ready), 64'd1);
    rd("after_rst_a", 2'b11, 8'h05, 8'h06, 2'b00, 32'h0, 32'h0);
    rd("after_rst_b", 2'b11, 8'h03, 8'h04, 2'b00, 32'h0, 32'h0);
    rd("after_rst_c", 2'b11, 8'h07, 8'h10, 2'b00, 32'h0, 32'h0);
    chk("after_rst_occ", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
